tx_capture_ctrl: RTL and testbench
==================================

Name: tx_capture_ctrl

Overview:
Sequencing controller for the PRBS -> FIR transmit datapath. It generates the datapath sample strobe from a free-running divider. It captures one FIR output word per strobe into an internal single-port RAM, and then streams the captured words back out on a ready-throttled read interface. It sits beside the PRBS and FIR in the tx top level and replaces the top's ad-hoc valid counter.

Parameters:
NB_COUNT, 3, divider width; strobe period = 2^NB_COUNT cycles
NB_DATA, 13, captured data width (FIR output width)
NB_ADDR, 10, RAM address width; depth = 2^NB_ADDR words

Ports:
clock  in  1  system clock
i_reset  in  1  synchronous, active-low reset
i_div_en  in  1  divider count enable; count holds when low
o_valid  out  1  one-cycle sample strobe to PRBS/FIR
i_data  in  NB_DATA  FIR output, registered by the FIR on the o_valid cycle
i_start  in  1  pulse: begin capture (IDLE only)
i_stop  in  1  pulse: end capture early (CAPTURE only)
i_rd_start  in  1  pulse: begin readback (DONE only)
i_rd_ready  in  1  sink ready for next read word
o_rd_data  out  NB_DATA  readback word
o_rd_valid  out  1  o_rd_data valid this cycle
o_count  out  NB_ADDR+1  number of words captured
o_state  out  2  IDLE=0, CAPTURE=1, DONE=2, READ=3
o_busy  out  1  state is CAPTURE or READ

Behaviour:
Reset (i_reset==0 at posedge) clears:
- divider, pointers and state; state = IDLE.
- outputs: o_valid=0, o_rd_valid=0, o_rd_data=0, o_count=0, o_busy=0.
- RAM contents are not cleared.
- Reset mid-capture or mid-read aborts immediately and loses no other state.

Divider:
- Free-running, independent of FSM state.
- o_valid=1 exactly when count==all-ones and i_div_en==1.
- valid_d is o_valid delayed by one cycle.

IDLE:
- i_start -> CAPTURE; wr_ptr<=0, o_count<=0.
- Other control inputs are ignored.

CAPTURE:
- On each cycle with valid_d==1: RAM[wr_ptr]<=i_data, wr_ptr++, o_count++.
- Write of address 2^NB_ADDR-1 -> DONE in the same edge; o_count = 2^NB_ADDR.
- i_stop -> DONE. If i_stop and a valid_d write coincide, the write completes and is counted.
- i_start is ignored.

DONE:
- Contents and o_count are held.
- i_rd_start with o_count==0 -> IDLE.
- i_rd_start with o_count>0 -> READ; rd_ptr<=0, issued<=0.

READ:
- RAM read latency is 1 cycle.
- A read issues at rd_ptr in each cycle where i_rd_ready==1 and issued<o_count. rd_ptr and issued then increment.
- o_rd_valid=1 and o_rd_data=RAM word in the cycle after each issue; otherwise o_rd_valid=0 and o_rd_data holds.
- After the last issued word's o_rd_valid cycle -> IDLE; o_count is retained until the next i_start.
- i_rd_ready low stalls issue only; an already-issued word still appears.

Arbitration:
- RAM is single-port.
- Writes occur only in CAPTURE and reads only in READ, so there is no conflict.

Widths:
- Pointers are NB_ADDR bits.
- o_count is NB_ADDR+1 bits and saturates at depth.

Optional Feature:
Macro: TX_CAPTURE_WRAP_EN.
- Defined: CAPTURE never auto-terminates.
  - wr_ptr wraps modulo depth, overwriting the oldest word.
  - o_count saturates at 2^NB_ADDR; a wrapped flag is set on the first wrap.
  - Only i_stop -> DONE.
  - READ starts at rd_ptr=wr_ptr if wrapped, else 0, and increments modulo depth. Output is therefore oldest-first.
- Undefined: stop-when-full behaviour exactly as above; no wrapped flag logic.

Decomposition:
Package tx_capture_pkg:
- state encoding constants ST_IDLE/ST_CAPTURE/ST_DONE/ST_READ.
- default NB_DATA/NB_ADDR/NB_COUNT constants.

Sub-module tx_capture_ram:
- single-port synchronous RAM, NB_DATA x 2^NB_ADDR.
- inputs: we, addr, wdata; output: registered rdata with 1-cycle latency.
- Instantiated once.

Test Plan (NB_COUNT=3, NB_ADDR=4, NB_DATA=13 unless stated):
- Divider: release reset, i_div_en=1 -> o_valid on cycles 7, 15, 23...; drop i_div_en for 5 cycles -> next pulse delayed 5 cycles.
- Full capture: i_start, i_data=valid-pulse index -> 16 writes, DONE after 16th valid_d, o_count=16. Further valid pulses write nothing.
- Early stop: i_start, i_stop after 5 writes in the same cycle as the 6th valid_d -> o_count=6, state DONE.
- Throttled readback: after 6-word capture, i_rd_start, i_rd_ready toggling 1,0,1,0... -> exactly 6 o_rd_valid pulses, data 0..5 in order, one cycle after each ready-high issue, then IDLE.
- Reset mid-READ after 3 words -> next cycle state=0, o_rd_valid=0, o_count=0. A new capture then works normally.
- TX_CAPTURE_WRAP_EN: capture 20 words (values 0..19), i_stop -> o_count=16; readback yields 4..19.

Source files
------------

// File: rtl/tx_capture_pkg.sv
// Shared constants and FSM state type for the transmit capture controller.
package tx_capture_pkg;

  localparam int unsigned NB_COUNT_DEF = 3;
  localparam int unsigned NB_DATA_DEF  = 13;
  localparam int unsigned NB_ADDR_DEF  = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2,
    ST_READ    = 2'd3
  } state_t;

endpackage

// File: rtl/tx_capture_ram.sv
// Single-port synchronous capture RAM, read data registered (1-cycle latency).
module tx_capture_ram
  import tx_capture_pkg::*;
#(
  parameter int unsigned NB_DATA = NB_DATA_DEF,
  parameter int unsigned NB_ADDR = NB_ADDR_DEF
) (
  input  logic               clock,
  input  logic               we,
  input  logic [NB_ADDR-1:0] addr,
  input  logic [NB_DATA-1:0] wdata,
  output logic [NB_DATA-1:0] rdata
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge clock) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/tx_capture_ctrl.sv
// Strobe divider, FIR-output capture and ready-throttled readback controller.
// Define TX_CAPTURE_WRAP_EN for circular capture (oldest-first readback).
module tx_capture_ctrl
  import tx_capture_pkg::*;
#(
  parameter int unsigned NB_COUNT = NB_COUNT_DEF,
  parameter int unsigned NB_DATA  = NB_DATA_DEF,
  parameter int unsigned NB_ADDR  = NB_ADDR_DEF
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_div_en,
  output logic               o_valid,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_rd_start,
  input  logic               i_rd_ready,
  output logic [NB_DATA-1:0] o_rd_data,
  output logic               o_rd_valid,
  output logic [NB_ADDR:0]   o_count,
  output logic [1:0]         o_state,
  output logic               o_busy
);

  localparam logic [NB_ADDR:0] DEPTH = {1'b1, {NB_ADDR{1'b0}}};

  state_t              state, state_nxt;
  logic [NB_COUNT-1:0] div_cnt;
  logic                valid_d;
  logic [NB_ADDR-1:0]  wr_ptr, rd_ptr, ram_addr;
  logic [NB_ADDR:0]    issued, count;
  logic                rd_valid_q;
  logic [NB_DATA-1:0]  rd_hold, ram_rdata;
  logic                wr_fire, wr_last, rd_issue;
`ifdef TX_CAPTURE_WRAP_EN
  logic                wrapped;
`endif

  assign o_valid  = i_div_en && (div_cnt == '1);
  assign wr_fire  = (state == ST_CAPTURE) && valid_d;
  assign wr_last  = (wr_ptr == '1);
  assign rd_issue = (state == ST_READ) && i_rd_ready && (issued < count);
  assign ram_addr = (state == ST_READ) ? rd_ptr : wr_ptr;

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      div_cnt <= '0;
      valid_d <= 1'b0;
    end else begin
      if (i_div_en) div_cnt <= div_cnt + 1'b1;
      valid_d <= o_valid;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (i_start) state_nxt = ST_CAPTURE;
      ST_CAPTURE: begin
`ifndef TX_CAPTURE_WRAP_EN
        if (wr_fire && wr_last) state_nxt = ST_DONE;
`endif
        if (i_stop) state_nxt = ST_DONE;
      end
      ST_DONE:    if (i_rd_start) state_nxt = (count == '0) ? ST_IDLE : ST_READ;
      // Leave only once the final issued word has been presented.
      ST_READ:    if (rd_valid_q && (issued == count)) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      issued     <= '0;
      count      <= '0;
      rd_valid_q <= 1'b0;
      rd_hold    <= '0;
`ifdef TX_CAPTURE_WRAP_EN
      wrapped    <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      rd_valid_q <= rd_issue;
      if (rd_valid_q) rd_hold <= ram_rdata;
      case (state)
        ST_IDLE: if (i_start) begin
          wr_ptr <= '0;
          count  <= '0;
`ifdef TX_CAPTURE_WRAP_EN
          wrapped <= 1'b0;
`endif
        end
        ST_CAPTURE: if (wr_fire) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (count != DEPTH) count <= count + 1'b1;
`ifdef TX_CAPTURE_WRAP_EN
          if (wr_last) wrapped <= 1'b1;
`endif
        end
        ST_DONE: if (i_rd_start) begin
`ifdef TX_CAPTURE_WRAP_EN
          rd_ptr <= wrapped ? wr_ptr : '0;
`else
          rd_ptr <= '0;
`endif
          issued <= '0;
        end
        ST_READ: if (rd_issue) begin
          rd_ptr <= rd_ptr + 1'b1;
          issued <= issued + 1'b1;
        end
        default: ;
      endcase
    end
  end

  tx_capture_ram #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clock (clock),
    .we    (wr_fire),
    .addr  (ram_addr),
    .wdata (i_data),
    .rdata (ram_rdata)
  );

  // RAM output wanders with the address; hold the last presented word.
  assign o_rd_data  = rd_valid_q ? ram_rdata : rd_hold;
  assign o_rd_valid = rd_valid_q;
  assign o_count    = count;
  assign o_state    = state;
  assign o_busy     = (state == ST_CAPTURE) || (state == ST_READ);

endmodule

// File: tb/tb_tx_capture_ctrl.sv
// Bench for tx_capture_ctrl: queue-based behavioural model plus directed literal checks.
module tb_tx_capture_ctrl;

  localparam int NB_COUNT = 3;
  localparam int NB_DATA  = 13;
  localparam int NB_ADDR  = 4;
  localparam int DEPTH    = 16;
  localparam int PERIOD   = 8;

  logic               clock = 1'b0;
  logic               i_reset = 1'b0;
  logic               i_div_en = 1'b0;
  logic               o_valid;
  logic [NB_DATA-1:0] i_data = '0;
  logic               i_start = 1'b0;
  logic               i_stop = 1'b0;
  logic               i_rd_start = 1'b0;
  logic               i_rd_ready = 1'b0;
  logic [NB_DATA-1:0] o_rd_data;
  logic               o_rd_valid;
  logic [NB_ADDR:0]   o_count;
  logic [1:0]         o_state;
  logic               o_busy;

  always #5 clock = ~clock;

  tx_capture_ctrl #(
    .NB_COUNT (NB_COUNT),
    .NB_DATA  (NB_DATA),
    .NB_ADDR  (NB_ADDR)
  ) dut (
    .clock      (clock),
    .i_reset    (i_reset),
    .i_div_en   (i_div_en),
    .o_valid    (o_valid),
    .i_data     (i_data),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_rd_start (i_rd_start),
    .i_rd_ready (i_rd_ready),
    .o_rd_data  (o_rd_data),
    .o_rd_valid (o_rd_valid),
    .o_count    (o_count),
    .o_state    (o_state),
    .o_busy     (o_busy)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;
  bit last_load = 0;
  int pulse_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer divider phase, memory array, queue of words left to read.
  int m_div = 0, m_state = 0, m_count = 0, m_wr = 0, m_out_data = 0;
  bit m_valid_d = 0, m_wrapped = 0, m_out_valid = 0;
  int m_mem [DEPTH];
  int m_rdq [$];

  task automatic model_step();
    bit v, nv;
    int base;
    if (!i_reset) begin
      m_div = 0; m_valid_d = 0; m_state = 0; m_count = 0; m_wr = 0;
      m_wrapped = 0; m_out_valid = 0; m_out_data = 0; m_rdq.delete();
    end else begin
      v  = (m_div == PERIOD - 1) && i_div_en;
      nv = 0;
      case (m_state)
        0: if (i_start) begin m_state = 1; m_wr = 0; m_count = 0; m_wrapped = 0; end
        1: begin
          if (m_valid_d) begin
            m_mem[m_wr] = int'(i_data);
            m_wr = (m_wr + 1) % DEPTH;
            if (m_count < DEPTH) m_count++;
            if (m_wr == 0) begin
`ifdef TX_CAPTURE_WRAP_EN
              m_wrapped = 1;
`else
              m_state = 2;
`endif
            end
          end
          if (i_stop) m_state = 2;
        end
        2: if (i_rd_start) begin
          if (m_count == 0) m_state = 0;
          else begin
            base = m_wrapped ? m_wr : 0;
            m_rdq.delete();
            for (int i = 0; i < m_count; i++) m_rdq.push_back(m_mem[(base + i) % DEPTH]);
            m_state = 3;
          end
        end
        default: begin
          if (m_out_valid && m_rdq.size() == 0) m_state = 0;
          else if (i_rd_ready && m_rdq.size() > 0) begin
            nv = 1;
            m_out_data = m_rdq.pop_front();
          end
        end
      endcase
      m_out_valid = nv;
      m_valid_d   = v;
      if (i_div_en) m_div = (m_div + 1) % PERIOD;
    end
  endtask

  always @(negedge clock) begin
    if (chk_on) begin
      check("o_valid",    o_valid,    (m_div == PERIOD - 1) && i_div_en);
      check("o_state",    o_state,    m_state);
      check("o_count",    o_count,    m_count);
      check("o_busy",     o_busy,     (m_state == 1) || (m_state == 3));
      check("o_rd_valid", o_rd_valid, m_out_valid);
      check("o_rd_data",  o_rd_data,  m_out_data);
    end
  end

  // One clock; also emulates the FIR registering a new word on each strobe.
  task automatic cyc();
    bit load;
    #1;
    load = o_valid;
    @(posedge clock);
    model_step();
    #1;
    last_load = load;
    if (load) begin
      i_data = NB_DATA'(pulse_idx);
      pulse_idx++;
    end
  endtask

  task automatic capture_stop(input int n_words, input string tag);
    int n;
    pulse_idx = 0;
    i_start = 1; cyc(); i_start = 0;
    n = last_load ? 1 : 0;
    for (int t = 0; t < 400 && n < n_words; t++) begin
      cyc();
      if (last_load) n++;
    end
    check({tag, "_reached"}, n, n_words);
    i_stop = 1; cyc(); i_stop = 0;
  endtask

  task automatic readback(input bit toggle, input int first, input int n_exp, input string tag);
    int got [$];
    bit idle;
    idle = 0;
    i_rd_start = 1; cyc(); i_rd_start = 0;
    for (int t = 0; t < 200; t++) begin
      i_rd_ready = toggle ? (t % 2 == 0) : 1'b1;
      cyc();
      if (o_rd_valid) got.push_back(int'(o_rd_data));
      if (o_state == 2'd0) begin idle = 1; break; end
    end
    i_rd_ready = 0;
    check({tag, "_idle"}, idle, 1);
    check({tag, "_nwords"}, got.size(), n_exp);
    for (int i = 0; i < n_exp; i++)
      check({tag, "_word"}, (i < got.size()) ? got[i] : -1, first + i);
  endtask

  initial begin
    int k, n;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 0;
    i_reset = 0; i_div_en = 1;
    cyc(); chk_on = 1; cyc();
    check("reset_state", o_state, 0);
    check("reset_count", o_count, 0);
    check("reset_rd_valid", o_rd_valid, 0);
    check("reset_rd_data", o_rd_data, 0);

    // Divider: pulses at cycles 7, 15, 23 after reset release.
    i_reset = 1;
    for (int c = 0; c < 24; c++) begin
      #1;
      check("div_pulse", o_valid, (c % 8 == 7));
      cyc();
    end
    i_div_en = 0;
    repeat (5) cyc();
    i_div_en = 1;
    k = 0;
    #1;
    while (k < 20 && !o_valid) begin cyc(); k++; end
    check("div_resume_gap", k, 7);

    // Empty capture: start in a valid_d cycle, stop before the next strobe.
    for (int t = 0; t < 20 && !last_load; t++) cyc();
    i_start = 1; cyc(); i_start = 0;
    i_stop = 1; cyc(); i_stop = 0;
    check("empty_state", o_state, 2);
    check("empty_count", o_count, 0);
    i_rd_start = 1; cyc(); i_rd_start = 0;
    check("empty_to_idle", o_state, 0);

    // Early stop coinciding with the 6th write.
    capture_stop(6, "early");
    check("early_state", o_state, 2);
    check("early_count", o_count, 6);
    readback(1'b1, 0, 6, "throttled");

    // Reset in the middle of a readback.
    capture_stop(6, "pre_reset");
    i_rd_start = 1; cyc(); i_rd_start = 0;
    i_rd_ready = 1;
    n = 0;
    for (int t = 0; t < 50 && n < 3; t++) begin cyc(); if (o_rd_valid) n++; end
    check("midread_words", n, 3);
    i_reset = 0; cyc(); i_reset = 1; i_rd_ready = 0;
    check("midread_reset_state", o_state, 0);
    check("midread_reset_rd_valid", o_rd_valid, 0);
    check("midread_reset_count", o_count, 0);
    capture_stop(6, "post_reset");
    check("post_reset_count", o_count, 6);
    readback(1'b0, 0, 6, "post_reset_read");

`ifndef TX_CAPTURE_WRAP_EN
    // Full capture terminates by itself at depth.
    pulse_idx = 0;
    i_start = 1; cyc(); i_start = 0;
    k = 0;
    while (k < 400 && o_state != 2'd2) begin cyc(); k++; end
    check("full_done", o_state, 2);
    check("full_count", o_count, 16);
    repeat (20) cyc();
    check("full_hold_count", o_count, 16);
    check("full_hold_state", o_state, 2);
    readback(1'b0, 0, 16, "full_read");
`else
    // Circular capture of 20 words returns the newest 16, oldest first.
    capture_stop(20, "wrap");
    check("wrap_state", o_state, 2);
    check("wrap_count", o_count, 16);
    readback(1'b0, 4, 16, "wrap_read");
`endif

    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
